regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the pipelined NPC core. It generalises the single-write/dual-read file to NRD read ports and NWR write ports, with optional same-cycle write-to-read bypass. It adds a per-register pending (scoreboard) bit that issue sets and writeback clears, and asynchronous active-low reset of all state. It sits between decode/issue (reads, allocation) and writeback (writes).

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of architectural registers; power of two, >= 2. AW = log2(NREGS) is derived, not overridable.
NRD, 2, number of read ports.
NWR, 1, number of write ports.
ZERO_REG, 1, if 1, register 0 reads as 0, ignores writes and is never pending.
BYPASS, 1, if 1, a same-cycle write is forwarded to matching read ports.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst_n  in  1  reset, asynchronous, active-low.
rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
rd_data  out  NRD*XLEN  read data, combinational; port i occupies [i*XLEN +: XLEN].
rd_busy  out  NRD  pending bit of the addressed register, combinational.
wr_en  in  NWR  per-port write enable.
wr_addr  in  NWR*AW  write addresses, packed like rd_addr.
wr_data  in  NWR*XLEN  write data, packed like rd_data.
alloc_en  in  1  mark alloc_addr pending at the next edge.
alloc_addr  in  AW  register being allocated by issue.
flush  in  1  clear all pending bits at the next edge (pipeline flush).

Behaviour:
- Reset: while rst_n=0, all registers = 0 and all pending bits = 0, taking effect immediately without waiting for clk. With all inputs idle, rd_data = 0 and rd_busy = 0. Reset asserted mid-operation discards any write in the same cycle.
- Read: zero latency, combinational from rd_addr and state.
  - ZERO_REG=1 and address 0: rd_data = 0 and rd_busy = 0 regardless of other inputs.
- Write: on the rising edge, for each port j with wr_en[j]=1, regs[wr_addr[j]] <= wr_data[j].
  - ZERO_REG=1: writes to address 0 are dropped.
  - Several enabled ports to the same address: the highest-index port wins.
- Bypass (BYPASS=1): if any enabled write port matches rd_addr[i] (and the address is not a suppressed register 0), rd_data[i] = the winning port's wr_data in the same cycle; otherwise the stored value is returned.
  - BYPASS=0: reads return the stored value only, and new data is visible the cycle after the edge.
- Pending bits, next-state at each edge, evaluated in order (later steps override earlier):
  1. pend[a] cleared for every write address a with wr_en=1.
  2. If flush=1, all pending bits cleared.
  3. If alloc_en=1, pend[alloc_addr] set.
  - So alloc beats a simultaneous write or flush to the same register: the new producer is outstanding.
  - Allocating register 0 with ZERO_REG=1 has no effect.
  - Writing a register that is not pending is legal; its bit stays 0.
- rd_busy[i] = pend[rd_addr[i]], except that with BYPASS=1 it reads 0 when a same-cycle enabled write matches rd_addr[i], since the data is being forwarded. Allocation only affects rd_busy from the next cycle.
- No X propagation: unwritten registers read 0 after reset.
- Out-of-range addresses are impossible, since NREGS is a power of two.

Test Plan:
1. Reset/zero: pulse rst_n low mid-cycle after writing x5=0x1234. Response: x5 reads 0 immediately, all rd_busy=0. Then write x0=0xFFFFFFFF: x0 still reads 0.
2. Write/read: write x3=0xDEADBEEF with BYPASS=1. Response: rd_data for rd_addr=3 equals 0xDEADBEEF in the same cycle and after the edge. With BYPASS=0 it shows the old value 0 until after the edge.
3. Write conflict (NWR=2): both ports write x7, port0=0x11 and port1=0x22. Response: x7=0x22 after the edge, and the bypassed read in the same cycle also shows 0x22.
4. Scoreboard: alloc x9. Response: rd_busy=1 from the next cycle. Then write x9=0x55: rd_busy=0 in the write cycle (bypass) and stays 0 after.
5. Alloc vs write/flush: in one cycle, write x4, assert flush, and alloc x4, with x2 also pending. Response: after the edge pend[4]=1, pend[2]=0, x4 holds the written data.
6. Parameter sweep: NREGS=16, XLEN=64, NRD=3, NWR=2, ZERO_REG=0. Response: x0 is writable and readable (0xA5A5A5A5A5A5A5A5), and all three read ports return correct data concurrently.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register pending bit (issue sets it, writeback clears it).
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                flush
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return ZR && (a == '0);
    endfunction

    // Later steps override earlier ones: writeback clear, then flush, then allocation.
    always_comb begin
        pend_nxt = pend;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) pend_nxt[wr_addr[j*AW +: AW]] = 1'b0;
        end
        if (flush) pend_nxt = '0;
        if (alloc_en && !is_zero_reg(alloc_addr)) pend_nxt[alloc_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Ascending port order makes the highest-index port the last assignment, so it wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && !is_zero_reg(wr_addr[j*AW +: AW])) begin
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            rbusy;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            rdat  = regs[ra];
            rbusy = pend[ra];
            if (BP) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
                        rdat  = wr_data[j*XLEN +: XLEN];
                        rbusy = 1'b0;
                    end
                end
            end
            if (is_zero_reg(ra)) begin
                rdat  = '0;
                rbusy = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = rdat;
        assign rd_busy[i]              = rbusy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations (bypass, no bypass, wide sweep)
// checked every cycle against an array model plus directed literal checks.
module tb_regfile_mp;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Stimulus views: index 0 = bypass instance, 1 = no-bypass instance, 2 = sweep instance.
    logic        v_wen   [3][2];
    int          v_waddr [3][2];
    logic [63:0] v_wdata [3][2];
    logic        v_alloc [3];
    int          v_aaddr [3];
    logic        v_flush [3];
    int          v_raddr [3][3];

    logic [9:0]   a_rd_addr;
    logic [63:0]  a_rd_data, b_rd_data;
    logic [1:0]   a_rd_busy, b_rd_busy;
    logic [1:0]   a_wr_en;
    logic [9:0]   a_wr_addr;
    logic [63:0]  a_wr_data;
    logic         a_alloc_en;
    logic [4:0]   a_alloc_addr;
    logic         a_flush;

    logic [11:0]  c_rd_addr;
    logic [191:0] c_rd_data;
    logic [2:0]   c_rd_busy;
    logic [1:0]   c_wr_en;
    logic [7:0]   c_wr_addr;
    logic [127:0] c_wr_data;
    logic         c_alloc_en;
    logic [3:0]   c_alloc_addr;
    logic         c_flush;

    int n_cmp  = 0;
    int n_fail = 0;

    always_comb begin
        a_wr_en   = '0;
        a_wr_addr = '0;
        a_wr_data = '0;
        a_rd_addr = '0;
        c_wr_en   = '0;
        c_wr_addr = '0;
        c_wr_data = '0;
        c_rd_addr = '0;
        for (int j = 0; j < 2; j++) begin
            a_wr_en[j]            = v_wen[0][j];
            a_wr_addr[j*5 +: 5]   = 5'(v_waddr[0][j]);
            a_wr_data[j*32 +: 32] = v_wdata[0][j][31:0];
            a_rd_addr[j*5 +: 5]   = 5'(v_raddr[0][j]);
            c_wr_en[j]            = v_wen[2][j];
            c_wr_addr[j*4 +: 4]   = 4'(v_waddr[2][j]);
            c_wr_data[j*64 +: 64] = v_wdata[2][j];
        end
        for (int i = 0; i < 3; i++) c_rd_addr[i*4 +: 4] = 4'(v_raddr[2][i]);
        a_alloc_en   = v_alloc[0];
        a_alloc_addr = 5'(v_aaddr[0]);
        a_flush      = v_flush[0];
        c_alloc_en   = v_alloc[2];
        c_alloc_addr = 4'(v_aaddr[2]);
        c_flush      = v_flush[2];
    end

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr), .flush(a_flush));

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr), .flush(a_flush));

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(2), .ZERO_REG(0), .BYPASS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .alloc_en(c_alloc_en), .alloc_addr(c_alloc_addr), .flush(c_flush));

    // ---------------- reference model ----------------
    logic [63:0] m_regs [3][32] = '{default: '{default: 64'h0}};
    bit          m_pend [3][32] = '{default: '{default: 1'b0}};

    function automatic bit zr_of(int k);  return k != 2; endfunction
    function automatic bit bp_of(int k);  return k != 1; endfunction
    function automatic int nrd_of(int k); return (k == 2) ? 3 : 2; endfunction

    always @(negedge rst_n) begin
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 32; r++) begin
                m_regs[k][r] = 64'h0;
                m_pend[k][r] = 1'b0;
            end
    end

    always @(posedge clk) begin : model_update
        bit np [32];
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                np = m_pend[k];
                for (int j = 0; j < 2; j++) begin
                    if (v_wen[k][j]) begin
                        if (!(zr_of(k) && v_waddr[k][j] == 0)) m_regs[k][v_waddr[k][j]] = v_wdata[k][j];
                        np[v_waddr[k][j]] = 1'b0;
                    end
                end
                if (v_flush[k]) for (int r = 0; r < 32; r++) np[r] = 1'b0;
                if (v_alloc[k] && !(zr_of(k) && v_aaddr[k] == 0)) np[v_aaddr[k]] = 1'b1;
                m_pend[k] = np;
            end
        end
    end

    function automatic logic [63:0] exp_data(int k, int i);
        int a;
        logic [63:0] d;
        a = v_raddr[k][i];
        if (zr_of(k) && a == 0) return 64'h0;
        d = m_regs[k][a];
        if (bp_of(k))
            for (int j = 0; j < 2; j++)
                if (v_wen[k][j] && v_waddr[k][j] == a) d = v_wdata[k][j];
        return d;
    endfunction

    function automatic logic [63:0] exp_busy(int k, int i);
        int a;
        a = v_raddr[k][i];
        if (zr_of(k) && a == 0) return 64'h0;
        if (bp_of(k))
            for (int j = 0; j < 2; j++)
                if (v_wen[k][j] && v_waddr[k][j] == a) return 64'h0;
        return {63'h0, m_pend[k][a]};
    endfunction

    function automatic logic [63:0] act_data(int k, int i);
        case (k)
            0:       return {32'h0, a_rd_data[i*32 +: 32]};
            1:       return {32'h0, b_rd_data[i*32 +: 32]};
            default: return c_rd_data[i*64 +: 64];
        endcase
    endfunction

    function automatic logic [63:0] act_busy(int k, int i);
        case (k)
            0:       return {63'h0, a_rd_busy[i]};
            1:       return {63'h0, b_rd_busy[i]};
            default: return {63'h0, c_rd_busy[i]};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < nrd_of(k); i++) begin
                n_cmp++;
                if (act_data(k, i) !== exp_data(k, i)) begin
                    n_fail++;
                    $display("FAIL model_data inst%0d port%0d t=%0t: got %h want %h",
                             k, i, $time, act_data(k, i), exp_data(k, i));
                end
                n_cmp++;
                if (act_busy(k, i) !== exp_busy(k, i)) begin
                    n_fail++;
                    $display("FAIL model_busy inst%0d port%0d t=%0t: got %0h want %0h",
                             k, i, $time, act_busy(k, i), exp_busy(k, i));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 2; j++) v_wen[k][j] = 1'b0;
            v_alloc[k] = 1'b0;
            v_flush[k] = 1'b0;
        end
    endtask

    task automatic ab_wr(input int j, input int a, input logic [63:0] d);
        for (int k = 0; k < 2; k++) begin
            v_wen[k][j]   = 1'b1;
            v_waddr[k][j] = a;
            v_wdata[k][j] = {32'h0, d[31:0]};
        end
    endtask

    task automatic ab_rd(input int i, input int a);
        v_raddr[0][i] = a;
        v_raddr[1][i] = a;
    endtask

    task automatic ab_alloc(input int a);
        for (int k = 0; k < 2; k++) begin
            v_alloc[k] = 1'b1;
            v_aaddr[k] = a;
        end
    endtask

    task automatic ab_flush();
        v_flush[0] = 1'b1;
        v_flush[1] = 1'b1;
    endtask

    task automatic c_wr(input int j, input int a, input logic [63:0] d);
        v_wen[2][j]   = 1'b1;
        v_waddr[2][j] = a;
        v_wdata[2][j] = d;
    endtask

    task automatic to_mid();
        @(negedge clk);
        #1;
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 2; j++) begin
                v_waddr[k][j] = 0;
                v_wdata[k][j] = 64'h0;
            end
            for (int i = 0; i < 3; i++) v_raddr[k][i] = 0;
            v_aaddr[k] = 0;
        end
        idle();
        ab_rd(0, 5);
        repeat (2) to_next();
        to_mid();
        chk("reset_data", act_data(0, 0), 64'h0);
        chk("reset_busy", act_busy(0, 0), 64'h0);
        to_next();
        rst_n = 1'b1;

        // Write x5, allocate x6, then an asynchronous reset pulse mid-cycle.
        ab_wr(0, 5, 64'h1234);
        ab_alloc(6);
        to_next();
        idle();
        ab_rd(0, 5);
        ab_rd(1, 6);
        to_mid();
        chk("x5_written", act_data(0, 0), 64'h1234);
        chk("x6_busy", act_busy(0, 1), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("x5_after_rst", act_data(0, 0), 64'h0);
        chk("x6_busy_after_rst", act_busy(0, 1), 64'h0);
        chk("sweep_busy_after_rst", {61'h0, c_rd_busy}, 64'h0);
        rst_n = 1'b1;

        // Register 0 is hardwired to zero.
        to_next();
        ab_wr(0, 0, 64'hFFFF_FFFF);
        ab_rd(0, 0);
        to_mid();
        chk("x0_write_cycle", act_data(0, 0), 64'h0);
        to_next();
        idle();
        to_mid();
        chk("x0_after_write", act_data(0, 0), 64'h0);

        // Bypass versus no bypass.
        to_next();
        ab_wr(0, 3, 64'hDEAD_BEEF);
        ab_rd(0, 3);
        to_mid();
        chk("x3_bypass_same_cycle", act_data(0, 0), 64'hDEAD_BEEF);
        chk("x3_nobypass_same_cycle", act_data(1, 0), 64'h0);
        to_next();
        idle();
        to_mid();
        chk("x3_bypass_after", act_data(0, 0), 64'hDEAD_BEEF);
        chk("x3_nobypass_after", act_data(1, 0), 64'hDEAD_BEEF);

        // Two ports write the same register: port 1 wins.
        to_next();
        ab_wr(0, 7, 64'h11);
        ab_wr(1, 7, 64'h22);
        ab_rd(0, 7);
        to_mid();
        chk("x7_conflict_bypass", act_data(0, 0), 64'h22);
        chk("x7_conflict_nobypass", act_data(1, 0), 64'h0);
        to_next();
        idle();
        to_mid();
        chk("x7_conflict_after", act_data(0, 0), 64'h22);
        chk("x7_conflict_after_nb", act_data(1, 0), 64'h22);

        // Scoreboard: allocate x9, then write it back.
        to_next();
        ab_alloc(9);
        ab_rd(1, 9);
        to_mid();
        chk("x9_busy_alloc_cycle", act_busy(0, 1), 64'h0);
        to_next();
        idle();
        to_mid();
        chk("x9_busy_next", act_busy(0, 1), 64'h1);
        chk("x9_busy_next_nb", act_busy(1, 1), 64'h1);
        to_next();
        ab_wr(0, 9, 64'h55);
        to_mid();
        chk("x9_busy_write_cycle", act_busy(0, 1), 64'h0);
        chk("x9_data_write_cycle", act_data(0, 1), 64'h55);
        chk("x9_busy_write_cycle_nb", act_busy(1, 1), 64'h1);
        to_next();
        idle();
        to_mid();
        chk("x9_busy_after", act_busy(0, 1), 64'h0);
        chk("x9_busy_after_nb", act_busy(1, 1), 64'h0);

        // Allocation beats a simultaneous write and flush.
        to_next();
        ab_alloc(2);
        to_next();
        idle();
        ab_wr(0, 4, 64'hABCD);
        ab_flush();
        ab_alloc(4);
        ab_rd(1, 2);
        to_mid();
        chk("x2_pending_before_flush", act_busy(0, 1), 64'h1);
        to_next();
        idle();
        ab_rd(0, 4);
        ab_rd(1, 2);
        to_mid();
        chk("x4_pending_after", act_busy(0, 0), 64'h1);
        chk("x2_flushed", act_busy(0, 1), 64'h0);
        chk("x4_data", act_data(0, 0), 64'hABCD);
        chk("x4_pending_after_nb", act_busy(1, 0), 64'h1);

        // Allocating register 0 has no effect when it is hardwired.
        to_next();
        ab_alloc(0);
        to_next();
        idle();
        ab_rd(0, 0);
        to_mid();
        chk("x0_never_pending", act_busy(0, 0), 64'h0);

        // Sweep configuration: x0 is an ordinary register, three concurrent reads.
        to_next();
        c_wr(0, 0, 64'hA5A5_A5A5_A5A5_A5A5);
        c_wr(1, 15, 64'h0123_4567_89AB_CDEF);
        v_raddr[2][0] = 0;
        v_raddr[2][1] = 15;
        v_raddr[2][2] = 8;
        to_mid();
        chk("sw_x0_bypass", act_data(2, 0), 64'hA5A5_A5A5_A5A5_A5A5);
        chk("sw_x15_bypass", act_data(2, 1), 64'h0123_4567_89AB_CDEF);
        chk("sw_x8_empty", act_data(2, 2), 64'h0);
        to_next();
        idle();
        c_wr(0, 8, 64'hFEDC_BA98_7654_3210);
        v_alloc[2] = 1'b1;
        v_aaddr[2] = 0;
        to_mid();
        chk("sw_x0_stored", act_data(2, 0), 64'hA5A5_A5A5_A5A5_A5A5);
        chk("sw_x15_stored", act_data(2, 1), 64'h0123_4567_89AB_CDEF);
        chk("sw_x8_bypass", act_data(2, 2), 64'hFEDC_BA98_7654_3210);
        to_next();
        idle();
        to_mid();
        chk("sw_x8_stored", act_data(2, 2), 64'hFEDC_BA98_7654_3210);
        chk("sw_x0_pending", act_busy(2, 0), 64'h1);

        // Mixed traffic over a small address window, checked by the model each cycle.
        for (int n = 0; n < 60; n++) begin
            to_next();
            idle();
            for (int j = 0; j < 2; j++) begin
                if ($urandom_range(1, 0) == 1) ab_wr(j, $urandom_range(7, 0), {32'h0, $urandom});
                if ($urandom_range(1, 0) == 1) c_wr(j, $urandom_range(7, 0), {$urandom, $urandom});
            end
            for (int i = 0; i < 2; i++) ab_rd(i, $urandom_range(7, 0));
            for (int i = 0; i < 3; i++) v_raddr[2][i] = $urandom_range(7, 0);
            if ($urandom_range(2, 0) == 0) ab_alloc($urandom_range(7, 0));
            if ($urandom_range(2, 0) == 0) begin
                v_alloc[2] = 1'b1;
                v_aaddr[2] = $urandom_range(7, 0);
            end
            if ($urandom_range(9, 0) == 0) ab_flush();
            if ($urandom_range(9, 0) == 0) v_flush[2] = 1'b1;
        end
        to_next();
        idle();
        to_mid();
        to_next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
